i2s_adc_receiver: RTL and testbench

I2S_ADC_RECEIVER -- requirements
Module: i2s_adc_receiver

---
 rtl/i2s_adc_receiver.sv | 185 ++++++++++++++++++
 tb/tb_i2s_adc_receiver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_receiver.sv
// i2s_adc_receiver
//   Receives stereo ADC samples from an audio codec over I2S (LJ_MODE=0) or
//   left-justified (LJ_MODE=1) framing. The codec clocks are oversampled by
//   clk (clk >= 4x aud_bclk) and every serial step advances only on a
//   synchronized rising edge of the bit clock.
//   A left word followed by a right word is committed as a pair and offered
//   with a valid/ready handshake.
//
// Ports
//   clk          system clock; all logic runs on its rising edge
//   rst_n        synchronous active-low reset
//   aud_bclk     codec bit clock (asynchronous to clk)
//   aud_adclrck  codec LR clock; 0 = left, 1 = right
//   aud_adcdat   codec serial data, MSB first
//   ldata/rdata  left/right sample of the committed pair
//   valid        committed pair available
//   ready        consumer accepts the pair when valid && ready
//   overrun      sticky: an unaccepted pair was overwritten
//   frame_err    sticky: a word was cut short by an LR clock change
//   clr_flags    single-cycle pulse clearing overrun and frame_err
module i2s_adc_receiver #(
  parameter int unsigned WIDTH   = 16,
  parameter bit          LJ_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             aud_bclk,
  input  logic             aud_adclrck,
  input  logic             aud_adcdat,
  output logic [WIDTH-1:0] ldata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_flags
);

  localparam int unsigned   CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    SYNC,
    DELAY,
    SHIFT,
    WAIT
  } state_t;

  // Synchronizer chains: [0] first stage, [1] second stage, [2] third stage.
  logic [2:0]       bclk_sq;
  logic [2:0]       lrck_sq;
  logic [2:0]       dat_sq;

  state_t           state_q;
  logic             lrck_prev_q;
  logic             chan_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] lhold_q;
  logic [WIDTH-1:0] rhold_q;
  logic             left_ok_q;
  logic             commit_q;
  logic [WIDTH-1:0] ldata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             valid_q;
  logic             overrun_q;
  logic             frame_err_q;

  logic             tick;
  logic             lrck;
  logic             dat;
  logic             start_word;
  logic [WIDTH-1:0] word_d;
  logic             unused_stage3;

  assign tick   = bclk_sq[1] & ~bclk_sq[2];
  assign lrck   = lrck_sq[1];
  assign dat    = dat_sq[1];
  assign word_d = {shift_q[WIDTH-2:0], dat};

  // Only the bit clock needs its third stage (edge detect); the third stages
  // of lrck/dat exist to keep all three paths equally deep.
  assign unused_stage3 = lrck_sq[2] ^ dat_sq[2];

  // A new word begins on an LR clock falling edge when hunting for frame
  // alignment, or on any LR clock change once aligned. A change while still
  // shifting means the previous word was short.
  assign start_word = ((state_q == SYNC) && lrck_prev_q && !lrck) ||
                      (((state_q == WAIT) || (state_q == SHIFT)) &&
                       (lrck != lrck_prev_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_sq     <= '0;
      lrck_sq     <= '0;
      dat_sq      <= '0;
      state_q     <= SYNC;
      lrck_prev_q <= 1'b0;
      chan_q      <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      lhold_q     <= '0;
      rhold_q     <= '0;
      left_ok_q   <= 1'b0;
      commit_q    <= 1'b0;
      ldata_q     <= '0;
      rdata_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bclk_sq  <= {bclk_sq[1:0], aud_bclk};
      lrck_sq  <= {lrck_sq[1:0], aud_adclrck};
      dat_sq   <= {dat_sq[1:0], aud_adcdat};
      commit_q <= 1'b0;

      // Clear first so that a flag set later in this block takes priority.
      if (clr_flags) begin
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end

      if (tick) begin
        lrck_prev_q <= lrck;
        if (start_word) begin
          chan_q <= lrck;
          if (state_q == SHIFT) begin
            frame_err_q <= 1'b1;
            left_ok_q   <= 1'b0;
          end
          if (LJ_MODE) begin
            shift_q <= word_d;
            cnt_q   <= CW'(1);
            state_q <= SHIFT;
          end else begin
            cnt_q   <= '0;
            state_q <= DELAY;
          end
        end else begin
          case (state_q)
            DELAY: begin
              shift_q <= word_d;
              cnt_q   <= CW'(1);
              state_q <= SHIFT;
            end
            SHIFT: begin
              shift_q <= word_d;
              cnt_q   <= cnt_q + 1'b1;
              if (cnt_q == LAST_BIT) begin
                if (!chan_q) begin
                  lhold_q   <= word_d;
                  left_ok_q <= 1'b1;
                end else begin
                  rhold_q  <= word_d;
                  commit_q <= left_ok_q;
                end
                state_q <= WAIT;
              end
            end
            default: ;
          endcase
        end
      end

      // Commit stage: runs one clk after the right word is stored.
      if (commit_q) begin
        ldata_q <= lhold_q;
        rdata_q <= rhold_q;
        valid_q <= 1'b1;
        if (valid_q && !ready) begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign ldata     = ldata_q;
  assign rdata     = rdata_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// tb_i2s_adc_receiver
//   Drives one codec serial stream into two receivers (I2S framing and
//   left-justified framing) with 16-bit words and checks pairs, handshake,
//   sticky flags, latency and reset behaviour against hand-computed values.
module tb_i2s_adc_receiver;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         bclk;
  logic         lrck;
  logic         dat_i2s;
  logic         dat_lj;
  logic         ready;
  logic         clr_flags;

  logic [W-1:0] ld_i2s, rd_i2s, ld_lj, rd_lj;
  logic         v_i2s, v_lj, ovr_i2s, ovr_lj, fe_i2s, fe_lj;

  int unsigned  n_cmp;
  int unsigned  n_mis;

  int unsigned  rises_i2s, rises_lj;
  time          t_rise_i2s, t_rise_lj;
  time          t_lsb_i2s, t_lsb_lj;
  logic         pv_i2s, pv_lj;

  i2s_adc_receiver #(.WIDTH(W), .LJ_MODE(1'b0)) u_i2s (
    .clk         (clk),
    .rst_n       (rst_n),
    .aud_bclk    (bclk),
    .aud_adclrck (lrck),
    .aud_adcdat  (dat_i2s),
    .ldata       (ld_i2s),
    .rdata       (rd_i2s),
    .valid       (v_i2s),
    .ready       (ready),
    .overrun     (ovr_i2s),
    .frame_err   (fe_i2s),
    .clr_flags   (clr_flags)
  );

  i2s_adc_receiver #(.WIDTH(W), .LJ_MODE(1'b1)) u_lj (
    .clk         (clk),
    .rst_n       (rst_n),
    .aud_bclk    (bclk),
    .aud_adclrck (lrck),
    .aud_adcdat  (dat_lj),
    .ldata       (ld_lj),
    .rdata       (rd_lj),
    .valid       (v_lj),
    .ready       (ready),
    .overrun     (ovr_lj),
    .frame_err   (fe_lj),
    .clr_flags   (clr_flags)
  );

  // clk period 10: posedges at 5 mod 10, negedges at 0 mod 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges of valid and note the clk edge on which each occurred.
  initial begin
    rises_i2s = 0;
    rises_lj  = 0;
    pv_i2s    = 1'b0;
    pv_lj     = 1'b0;
    t_rise_i2s = 0;
    t_rise_lj  = 0;
  end

  always @(posedge clk) begin
    #1;
    if (v_i2s === 1'b1 && pv_i2s !== 1'b1) begin
      rises_i2s++;
      t_rise_i2s = $time - 1;
    end
    if (v_lj === 1'b1 && pv_lj !== 1'b1) begin
      rises_lj++;
      t_rise_lj = $time - 1;
    end
    pv_i2s = v_i2s;
    pv_lj  = v_lj;
  end

  task automatic check(input string tag, input logic [31:0] obs_v,
                       input logic [31:0] exp_v);
    n_cmp++;
    if (obs_v !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  // One channel of n bit-clock periods (80 ns each, 8 clk). LR clock and data
  // change on the falling edge. I2S carries word bits in periods 1..16, LJ in
  // periods 0..15; every other period carries a 1 that must be ignored.
  task automatic send_channel(input logic ch, input logic [W-1:0] w,
                              input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      bclk    = 1'b0;
      lrck    = ch;
      dat_i2s = (k >= 1 && k <= W) ? w[W-k] : 1'b1;
      dat_lj  = (k < W) ? w[W-1-k] : 1'b1;
      #40;
      bclk = 1'b1;
      if (ch && k == W)     t_lsb_i2s = $time;
      if (ch && k == W - 1) t_lsb_lj  = $time;
      #40;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
  endtask

  int unsigned r0_i2s, r0_lj;

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    rst_n     = 1'b0;
    bclk      = 1'b0;
    lrck      = 1'b0;
    dat_i2s   = 1'b0;
    dat_lj    = 1'b0;
    ready     = 1'b1;
    clr_flags = 1'b0;
    t_lsb_i2s = 0;
    t_lsb_lj  = 0;

    repeat (4) @(negedge clk);
    check("rst i2s valid",   32'(v_i2s),   32'd0);
    check("rst lj valid",    32'(v_lj),    32'd0);
    check("rst i2s ldata",   32'(ld_i2s),  32'd0);
    check("rst lj rdata",    32'(rd_lj),   32'd0);
    check("rst i2s overrun", 32'(ovr_i2s), 32'd0);
    check("rst lj frame",    32'(fe_lj),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pair after a lead-in right channel that carries no LR fall.
    send_channel(1'b1, 16'h0000, 32);
    send_channel(1'b0, 16'hA55A, 32);
    send_channel(1'b1, 16'h1234, 32);
    check("A i2s rises",   rises_i2s,    32'd1);
    check("A lj rises",    rises_lj,     32'd1);
    check("A i2s ldata",   32'(ld_i2s),  32'hA55A);
    check("A i2s rdata",   32'(rd_i2s),  32'h1234);
    check("A lj ldata",    32'(ld_lj),   32'hA55A);
    check("A lj rdata",    32'(rd_lj),   32'h1234);
    check("A i2s valid",   32'(v_i2s),   32'd0);
    check("A i2s overrun", 32'(ovr_i2s), 32'd0);
    check("A lj frame",    32'(fe_lj),   32'd0);
    // valid rises on the 4th clk posedge after the LSB bclk rise: +5,+15,+25,+35
    check("A i2s latency", 32'(t_rise_i2s - t_lsb_i2s), 32'd35);
    check("A lj latency",  32'(t_rise_lj - t_lsb_lj),   32'd35);

    // Surplus bits (ones) after each word must be ignored.
    send_channel(1'b0, 16'h8001, 32);
    send_channel(1'b1, 16'h7FFE, 32);
    check("B i2s rises", rises_i2s,   32'd2);
    check("B lj rises",  rises_lj,    32'd2);
    check("B i2s ldata", 32'(ld_i2s), 32'h8001);
    check("B i2s rdata", 32'(rd_i2s), 32'h7FFE);
    check("B lj ldata",  32'(ld_lj),  32'h8001);
    check("B lj rdata",  32'(rd_lj),  32'h7FFE);

    // Back-pressure: second pair overwrites the first and flags overrun.
    @(negedge clk);
    ready = 1'b0;
    send_channel(1'b0, 16'h1111, 32);
    send_channel(1'b1, 16'h2222, 32);
    send_channel(1'b0, 16'h3333, 32);
    send_channel(1'b1, 16'h4444, 32);
    check("C i2s valid",   32'(v_i2s),   32'd1);
    check("C lj valid",    32'(v_lj),    32'd1);
    check("C i2s ldata",   32'(ld_i2s),  32'h3333);
    check("C i2s rdata",   32'(rd_i2s),  32'h4444);
    check("C lj ldata",    32'(ld_lj),   32'h3333);
    check("C lj rdata",    32'(rd_lj),   32'h4444);
    check("C i2s overrun", 32'(ovr_i2s), 32'd1);
    check("C lj overrun",  32'(ovr_lj),  32'd1);
    check("C i2s rises",   rises_i2s,    32'd3);
    pulse_clr();
    check("C i2s ovr clr", 32'(ovr_i2s), 32'd0);
    check("C lj ovr clr",  32'(ovr_lj),  32'd0);
    check("C i2s hold",    32'(v_i2s),   32'd1);
    ready = 1'b1;
    @(negedge clk);
    check("C i2s accept",  32'(v_i2s),   32'd0);
    check("C lj accept",   32'(v_lj),    32'd0);

    // Short left word: frame error, following right word is not committed.
    r0_i2s = rises_i2s;
    r0_lj  = rises_lj;
    send_channel(1'b0, 16'hFFFF, 11);
    send_channel(1'b1, 16'h5555, 32);
    check("D i2s frame",     32'(fe_i2s),  32'd1);
    check("D lj frame",      32'(fe_lj),   32'd1);
    check("D i2s no commit", rises_i2s,    r0_i2s);
    check("D lj no commit",  rises_lj,     r0_lj);
    check("D i2s rdata old", 32'(rd_i2s),  32'h4444);
    send_channel(1'b0, 16'h6666, 32);
    send_channel(1'b1, 16'h7777, 32);
    check("D i2s rises",     rises_i2s,    r0_i2s + 1);
    check("D lj rises",      rises_lj,     r0_lj + 1);
    check("D i2s ldata",     32'(ld_i2s),  32'h6666);
    check("D i2s rdata",     32'(rd_i2s),  32'h7777);
    check("D lj ldata",      32'(ld_lj),   32'h6666);
    check("D lj rdata",      32'(rd_lj),   32'h7777);
    pulse_clr();
    check("D i2s frame clr", 32'(fe_i2s),  32'd0);
    check("D lj frame clr",  32'(fe_lj),   32'd0);

    // Reset in the middle of a right word (8 I2S bits in).
    send_channel(1'b0, 16'hAAAA, 32);
    send_channel(1'b1, 16'h9999, 9);
    r0_i2s = rises_i2s;
    r0_lj  = rises_lj;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("E i2s ldata", 32'(ld_i2s), 32'd0);
    check("E i2s rdata", 32'(rd_i2s), 32'd0);
    check("E lj ldata",  32'(ld_lj),  32'd0);
    check("E lj rdata",  32'(rd_lj),  32'd0);
    check("E i2s valid", 32'(v_i2s),  32'd0);
    send_channel(1'b1, 16'h9999, 23);
    send_channel(1'b0, 16'hBBBB, 32);
    check("E i2s no valid", rises_i2s, r0_i2s);
    check("E lj no valid",  rises_lj,  r0_lj);
    send_channel(1'b1, 16'hCCCC, 32);
    check("E i2s rises", rises_i2s,   r0_i2s + 1);
    check("E lj rises",  rises_lj,    r0_lj + 1);
    check("E i2s ldata", 32'(ld_i2s), 32'hBBBB);
    check("E i2s rdata", 32'(rd_i2s), 32'hCCCC);
    check("E lj ldata",  32'(ld_lj),  32'hBBBB);
    check("E lj rdata",  32'(rd_lj),  32'hCCCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
